// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI-to-single-port-SRAM slave: FSM encoding,
// response codes and the default RAM word-address width.
package axi_sram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_RESP = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam int         RAM_AW_DEFAULT = 16;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI slave in front of an external single-port 32-bit SRAM with one-cycle read
// latency; one transaction in flight, round-robin grant between AR and AW.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,

    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,

    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t            state;
    logic              prio_rd;
    logic [RAM_AW-1:0] addr;
    logic [7:0]        len;
    logic [7:0]        beat;
    logic              ar_hs;
    logic              aw_hs;
    logic              w_hs;

    // Burst shape, ordering and protection attributes carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{arsize, arburst, arlock, arcache, arprot, araddr,
                             awsize, awburst, awlock, awcache, awprot, awaddr,
                             wid, wlast};

    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        if (!reset && state == IDLE) begin
            arready = arvalid && (prio_rd || !awvalid);
            awready = awvalid && (!prio_rd || !arvalid);
        end
    end

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // The RAM strobes must never fire while reset is held, even for one cycle.
    assign ram_en    = !reset && (state == RD_REQ || w_hs);
    assign ram_we    = (!reset && w_hs) ? wstrb : 4'b0000;
    assign ram_addr  = addr;
    assign ram_wdata = wdata;

    assign rresp = RESP_OKAY;
    assign bresp = RESP_OKAY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            prio_rd <= 1'b1;
            addr    <= '0;
            len     <= '0;
            beat    <= '0;
            rid     <= '0;
            rdata   <= '0;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
            wready  <= 1'b0;
            bid     <= '0;
            bvalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        rid     <= arid;
                        addr    <= araddr[RAM_AW+1:2];
                        len     <= arlen;
                        beat    <= '0;
                        prio_rd <= 1'b0;
                        state   <= RD_REQ;
                    end else if (aw_hs) begin
                        bid     <= awid;
                        addr    <= awaddr[RAM_AW+1:2];
                        len     <= awlen;
                        beat    <= '0;
                        prio_rd <= 1'b1;
                        wready  <= 1'b1;
                        state   <= WR_DATA;
                    end
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    rdata  <= ram_rdata;
                    rlast  <= (beat == len);
                    rvalid <= 1'b1;
                    state  <= RD_RESP;
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (rlast) begin
                            state <= IDLE;
                        end else begin
                            beat  <= beat + 8'd1;
                            addr  <= addr + RAM_AW'(1);
                            state <= RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    // awlen alone ends the burst; wlast is not trusted.
                    if (wvalid) begin
                        if (beat == len) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            state  <= WR_RESP;
                        end else begin
                            beat <= beat + 8'd1;
                            addr <= addr + RAM_AW'(1);
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
